// File: rtl/arbiter_puf_ctrl.sv
// Challenge/response sequencer for an arbiter PUF: settle, fire, wait, sample per challenge.
// Define PUF_VOTE_EN to evaluate each challenge VOTES times and store the majority bit.
module arbiter_puf_ctrl #(
   parameter int CHAL_W     = 1,
   parameter int NRESP      = 8,
   parameter int SETTLE_CYC = 2,
   parameter int PULSE_CYC  = 2,
   parameter int CAPT_CYC   = 3,
   parameter int VOTES      = 3
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              istart,
   input  logic [CHAL_W-1:0] ichal_base,
   output logic              obusy,
   output logic              opulse,
   output logic [CHAL_W-1:0] ochallenge,
   input  logic              iresponse,
   output logic [NRESP-1:0]  oresp_data,
   output logic              oresp_valid,
   input  logic              iresp_ready,
   output logic [2:0]        odbg_state
);

   // Handshake: the word transfers on any cycle where oresp_valid & iresp_ready are both high.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_FIRE   = 3'd2,
      S_WAIT   = 3'd3,
      S_SAMPLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam int MAXC  = (SETTLE_CYC > PULSE_CYC) ?
                          ((SETTLE_CYC > CAPT_CYC) ? SETTLE_CYC : CAPT_CYC) :
                          ((PULSE_CYC > CAPT_CYC) ? PULSE_CYC : CAPT_CYC);
   localparam int CNT_W = $clog2(MAXC + 1);
   localparam int IDX_W = (NRESP > 1) ? $clog2(NRESP) : 1;

   if (NRESP < 1 || SETTLE_CYC < 1 || PULSE_CYC < 1 || CAPT_CYC < 2 ||
       VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_param
      $error("arbiter_puf_ctrl: illegal parameter combination");
   end

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [1:0]         sync_q;
   logic [CHAL_W-1:0]  chal_q;
   logic [NRESP-1:0]   data_q;
   logic               pulse_q;
   logic               valid_q;
   logic               busy_q;
   logic               last_vote;
   logic               bit_d;

   // The PUF output is asynchronous to iclk; only sync_q[1] is ever consumed.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], iresponse};
   end

`ifdef PUF_VOTE_EN
   localparam int VW = $clog2(VOTES + 1);
   logic [VW-1:0] vote_q;
   logic [VW-1:0] ones_q;
   logic [VW-1:0] ones_d;

   assign ones_d    = ones_q + VW'(sync_q[1]);
   assign last_vote = (vote_q == VW'(VOTES - 1));
   assign bit_d     = (ones_d > VW'(VOTES / 2));
`else
   assign last_vote = 1'b1;
   assign bit_d     = sync_q[1];
`endif

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         chal_q  <= '0;
         data_q  <= '0;
         pulse_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef PUF_VOTE_EN
         vote_q  <= '0;
         ones_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (istart) begin
                  state_q <= S_SETUP;
                  chal_q  <= ichal_base;
                  data_q  <= '0;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
`ifdef PUF_VOTE_EN
                  vote_q  <= '0;
                  ones_q  <= '0;
`endif
               end
            end
            S_SETUP: begin
               if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                  cnt_q   <= '0;
                  pulse_q <= 1'b1;
                  state_q <= S_FIRE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_FIRE: begin
               if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                  cnt_q   <= '0;
                  pulse_q <= 1'b0;
                  state_q <= S_WAIT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_W'(CAPT_CYC - 1)) begin
                  cnt_q   <= '0;
                  state_q <= S_SAMPLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_SAMPLE: begin
               state_q <= S_SETUP;
               if (last_vote) begin
                  data_q[idx_q] <= bit_d;
                  if (idx_q == IDX_W'(NRESP - 1)) begin
                     state_q <= S_DONE;
                     valid_q <= 1'b1;
                  end else begin
                     idx_q  <= idx_q + IDX_W'(1);
                     chal_q <= chal_q + CHAL_W'(1);
                  end
               end
`ifdef PUF_VOTE_EN
               vote_q <= last_vote ? '0 : vote_q + VW'(1);
               ones_q <= last_vote ? '0 : ones_d;
`endif
            end
            S_DONE: begin
               if (iresp_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign obusy       = busy_q;
   assign opulse      = pulse_q;
   assign ochallenge  = chal_q;
   assign oresp_data  = data_q;
   assign oresp_valid = valid_q;
   assign odbg_state  = state_q;

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Bench for arbiter_puf_ctrl: vector table, randomized PUF maps, multi-cycle corner cases.
module tb_arbiter_puf_ctrl;

   localparam int CHAL_W     = 1;
   localparam int NRESP      = 8;
   localparam int SETTLE_CYC = 2;
   localparam int PULSE_CYC  = 2;
   localparam int CAPT_CYC   = 3;
   localparam int VOTES      = 3;
   localparam int T          = SETTLE_CYC + PULSE_CYC + CAPT_CYC + 1;
`ifdef PUF_VOTE_EN
   localparam int E          = VOTES;
`else
   localparam int E          = 1;
`endif
   localparam int LAT        = NRESP * T * E;
   localparam int NCHAL      = 1 << CHAL_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              istart;
   logic [CHAL_W-1:0] ichal_base;
   logic              obusy;
   logic              opulse;
   logic [CHAL_W-1:0] ochallenge;
   logic              iresponse;
   logic [NRESP-1:0]  oresp_data;
   logic              oresp_valid;
   logic              iresp_ready;
   logic [2:0]        dbg_state;

   arbiter_puf_ctrl #(
      .CHAL_W(CHAL_W), .NRESP(NRESP), .SETTLE_CYC(SETTLE_CYC),
      .PULSE_CYC(PULSE_CYC), .CAPT_CYC(CAPT_CYC), .VOTES(VOTES)
   ) dut (
      .iclk(clk), .irst_n(rst_n), .istart(istart), .ichal_base(ichal_base),
      .obusy(obusy), .opulse(opulse), .ochallenge(ochallenge),
      .iresponse(iresponse), .oresp_data(oresp_data), .oresp_valid(oresp_valid),
      .iresp_ready(iresp_ready), .odbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // PUF model: a challenge->bit map, optional inversion, two-cycle delay, and in the
   // voting build the first evaluation of every challenge is corrupted.
   logic              puf_map [NCHAL];
   logic              puf_inv = 1'b0;
   int                pulse_cnt = 0;
   logic              pulse_prev = 1'b0;
   logic [1:0]        resp_pipe = 2'b00;
   logic              corrupt;
   logic [CHAL_W-1:0] base_lat = '0;

`ifdef PUF_VOTE_EN
   assign corrupt = ((pulse_cnt % VOTES) == 1);
`else
   assign corrupt = 1'b0;
`endif
   assign iresponse = resp_pipe[1];

   always @(posedge clk) begin
      pulse_prev <= opulse;
      if (istart && !obusy) begin
         pulse_cnt <= 0;
         base_lat  <= ichal_base;
      end else if (opulse && !pulse_prev) begin
         pulse_cnt <= pulse_cnt + 1;
      end
      resp_pipe <= {resp_pipe[0], puf_map[ochallenge] ^ puf_inv ^ corrupt};
   end

   // Protocol monitor: pulse width, challenge stable while pulsing, challenge order.
   int                viol = 0;
   int                pw = 0;
   logic [CHAL_W-1:0] chal_prev = '0;
   logic [CHAL_W-1:0] chal_exp;

   assign chal_exp = CHAL_W'((int'(base_lat) + pulse_cnt / E) % NCHAL);

   always @(posedge clk) begin
      chal_prev <= ochallenge;
      if (!rst_n) begin
         pw <= 0;
      end else begin
         if (opulse && ochallenge !== chal_prev) viol <= viol + 1;
         if (opulse && !pulse_prev && ochallenge !== chal_exp) viol <= viol + 1;
         if (opulse) begin
            pw <= pw + 1;
         end else begin
            if (pw != 0 && pw != PULSE_CYC) viol <= viol + 1;
            pw <= 0;
         end
      end
   end

   function automatic logic [NRESP-1:0] model_word(input int base);
      logic [NRESP-1:0] w;
      for (int i = 0; i < NRESP; i++) w[i] = puf_map[(base + i) % NCHAL] ^ puf_inv;
      return w;
   endfunction

   task automatic do_word(input logic [CHAL_W-1:0] base, input int rwait,
                          input logic glitch, input logic [NRESP-1:0] exp, input string tag);
      int               lat;
      logic [NRESP-1:0] got;
      logic             g_done;
      @(negedge clk);
      istart     = 1'b1;
      ichal_base = base;
      @(negedge clk);
      istart = 1'b0;
      check($sformatf("%s busy_after_start", tag), obusy, 1);
      lat    = 0;
      g_done = 1'b0;
      while (!oresp_valid && lat < LAT + 50) begin
         istart = 1'b0;
         if (glitch && opulse && !g_done) begin
            istart = 1'b1;
            g_done = 1'b1;
         end
         @(negedge clk);
         lat++;
      end
      istart = 1'b0;
      check($sformatf("%s latency", tag), lat, LAT);
      got = oresp_data;
      check($sformatf("%s data", tag), got, exp);
      for (int j = 0; j < rwait; j++) begin
         @(negedge clk);
         check($sformatf("%s hold%0d", tag, j), {oresp_valid, obusy, oresp_data}, {2'b11, exp});
      end
      iresp_ready = 1'b1;
      istart      = glitch;
      @(negedge clk);
      iresp_ready = 1'b0;
      istart      = 1'b0;
      check($sformatf("%s after_handshake", tag), {oresp_valid, obusy}, 2'b00);
      if (glitch) begin
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("%s stays_idle%0d", tag, j), {obusy, oresp_data}, {1'b0, exp});
         end
      end
   endtask

   typedef struct {
      logic [CHAL_W-1:0] base;
      logic              inv;
      int                rwait;
      logic              glitch;
      logic [NRESP-1:0]  exp;
   } vec_t;

   vec_t tbl [4];

   initial begin
      logic [CHAL_W-1:0] rb;
      int                guard;

      tbl[0] = '{base: CHAL_W'(0), inv: 1'b0, rwait: 20, glitch: 1'b0, exp: 8'hAA};
      tbl[1] = '{base: CHAL_W'(1), inv: 1'b0, rwait: 0,  glitch: 1'b0, exp: 8'h55};
      tbl[2] = '{base: CHAL_W'(0), inv: 1'b1, rwait: 3,  glitch: 1'b1, exp: 8'h55};
      tbl[3] = '{base: CHAL_W'(1), inv: 1'b1, rwait: 1,  glitch: 1'b0, exp: 8'hAA};

      for (int i = 0; i < NCHAL; i++) puf_map[i] = i[0];
      rst_n       = 1'b0;
      istart      = 1'b0;
      ichal_base  = '0;
      iresp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle obusy", obusy, 0);
      check("idle opulse", opulse, 0);
      check("idle ochallenge", ochallenge, 0);
      check("idle oresp_data", oresp_data, 0);
      check("idle oresp_valid", oresp_valid, 0);

      for (int v = 0; v < 4; v++) begin
         puf_inv = tbl[v].inv;
         do_word(tbl[v].base, tbl[v].rwait, tbl[v].glitch, tbl[v].exp, $sformatf("vec%0d", v));
      end

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NCHAL; i++) puf_map[i] = 1'($urandom_range(0, 1));
         puf_inv = 1'($urandom_range(0, 1));
         rb      = CHAL_W'($urandom_range(0, NCHAL - 1));
         do_word(rb, $urandom_range(0, 5), 1'b0, model_word(int'(rb)), $sformatf("rnd%0d", r));
      end

      // Abort in the middle of the third race pulse.
      for (int i = 0; i < NCHAL; i++) puf_map[i] = i[0];
      puf_inv = 1'b0;
      @(negedge clk);
      istart     = 1'b1;
      ichal_base = '0;
      @(negedge clk);
      istart = 1'b0;
      guard  = 0;
      while (!(opulse && pulse_cnt >= 3) && guard < LAT) begin
         @(negedge clk);
         guard++;
      end
      check("third_fire reached", (guard < LAT), 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort opulse", opulse, 0);
      check("abort obusy", obusy, 0);
      check("abort ochallenge", ochallenge, 0);
      check("abort oresp_data", oresp_data, 0);
      check("abort oresp_valid", oresp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_word(CHAL_W'(0), 2, 1'b0, 8'hAA, "post_reset");

      check("protocol violations", viol, 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
